// File: rtl/act_unit_pipe.sv
// Multi-lane activation stage (bypass / ReLU / clipped ReLU / leaky ReLU) behind the MAC array.
// Two registered stages with valid/ready backpressure and a saturating clamp counter.
module act_unit_pipe #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       clip_max,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_clamped,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       clamp_cnt
);

  // Handshake: a beat moves across an interface on the clock edge where valid
  // and ready are both high; valid never depends on ready, and a stalled output
  // (out_valid & !out_ready) keeps out_data/out_clamped unchanged.

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic                    s1_valid;
  logic [1:0]              s1_mode;
  logic signed [WIDTH-1:0] s1_clip;
  logic [LANES*WIDTH-1:0]  s1_data;

  logic                    s1_adv;
  logic                    in_xfer;
  logic                    out_xfer;
  logic signed [WIDTH-1:0] clip_pos;
  logic [LANES*WIDTH-1:0]  act_data;
  logic [LANES-1:0]        act_clamp;
  logic [PC_W-1:0]         pc;
  logic [SUM_W-1:0]        cnt_sum;

  assign out_xfer = out_valid & out_ready;
  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & (~s1_valid | s1_adv);
  assign in_xfer  = in_valid & in_ready;

  // A negative bound collapses to zero so clipped ReLU never passes negatives.
  assign clip_pos = s1_clip[WIDTH-1] ? '0 : s1_clip;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic                    f;
    logic                    non_pos;

    assign x       = s1_data[i*WIDTH +: WIDTH];
    assign non_pos = x[WIDTH-1] | (x == '0);

    always_comb begin
      y = x;
      f = 1'b0;
      case (s1_mode)
        2'd1: if (non_pos) y = '0;
        2'd2: begin
          if (non_pos) begin
            y = '0;
          end else if (x > clip_pos) begin
            y = clip_pos;
            f = 1'b1;
          end
        end
        2'd3: if (x[WIDTH-1]) y = x >>> LEAK_SHIFT;
        default: y = x;
      endcase
    end

    assign act_data[i*WIDTH +: WIDTH] = y;
    assign act_clamp[i]               = f;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) pc = pc + PC_W'(out_clamped[i]);
  end

  assign cnt_sum = SUM_W'(clamp_cnt) + SUM_W'(pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_mode     <= 2'd0;
      s1_clip     <= '0;
      s1_data     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_clamped <= '0;
      clamp_cnt   <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_mode  <= mode;
        s1_clip  <= clip_max;
        s1_data  <= in_data;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid   <= 1'b1;
        out_data    <= act_data;
        out_clamped <= act_clamp;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      if (clr_cnt) begin
        clamp_cnt <= '0;
      end else if (out_xfer) begin
        if (cnt_sum > SUM_W'({CNT_W{1'b1}})) clamp_cnt <= {CNT_W{1'b1}};
        else                                 clamp_cnt <= cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Bench for act_unit_pipe: directed vectors plus a randomized stream under random
// backpressure, checked by an expected-queue scoreboard and a counter model.
module tb_act_unit_pipe;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int LS = 3;
  localparam int CW = 4;
  localparam int DW = L * W;
  localparam int EW = DW + L;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic [W-1:0]  clip_max;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [L-1:0]  out_clamped;
  logic          clr_cnt;
  logic [CW-1:0] clamp_cnt;

  act_unit_pipe #(
    .WIDTH(W), .FRAC(8), .LANES(L), .LEAK_SHIFT(LS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .clip_max(clip_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_clamped(out_clamped), .clr_cnt(clr_cnt), .clamp_cnt(clamp_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            model_cnt = 0;
  bit            held_v = 0;
  logic [EW-1:0] held;
  bit            rand_ready = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: activation per lane with integer arithmetic, flags in the top bits.
  function automatic logic [EW-1:0] model(input logic [1:0] m, input logic [W-1:0] c,
                                          input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [L-1:0]  f;
    int x, y, cl, div;
    r   = '0;
    f   = '0;
    div = 1 << LS;
    cl  = int'($signed(c));
    if (cl < 0) cl = 0;
    for (int i = 0; i < L; i++) begin
      x = int'($signed(d[i*W +: W]));
      case (m)
        2'd0: y = x;
        2'd1: y = (x > 0) ? x : 0;
        2'd2: begin
          if (x <= 0) y = 0;
          else if (x > cl) begin y = cl; f[i] = 1'b1; end
          else y = x;
        end
        default: y = (x >= 0) ? x : -((-x + div - 1) / div);
      endcase
      r[i*W +: W] = y[W-1:0];
    end
    return {f, r};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    bool_block: begin
      if (rst) begin
        exp_q.delete();
        model_cnt = 0;
        held_v    = 0;
      end else begin
        e = '0;
        check("clamp_cnt", 128'(clamp_cnt), 128'(model_cnt));
        if (held_v && out_valid) check("stall_hold", 128'({out_clamped, out_data}), 128'(held));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %h, expected no beat", {out_clamped, out_data});
          end else begin
            e = exp_q.pop_front();
            check("out_beat", 128'({out_clamped, out_data}), 128'(e));
          end
        end
        if (clr_cnt) model_cnt = 0;
        else if (out_valid && out_ready) begin
          model_cnt = model_cnt + $countones(e[EW-1:DW]);
          if (model_cnt > (1 << CW) - 1) model_cnt = (1 << CW) - 1;
        end
        held_v = out_valid && !out_ready;
        held   = {out_clamped, out_data};
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] m, input logic [W-1:0] c,
                           input logic [DW-1:0] d, input logic [EW-1:0] e);
    bit acc;
    int t;
    acc = 0;
    t   = 0;
    mode = m; clip_max = c; in_data = d; in_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      tick();
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", t);
    end
  endtask

  task automatic send_model(input logic [1:0] m, input logic [W-1:0] c, input logic [DW-1:0] d);
    send_beat(m, c, d, model(m, c, d));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [W-1:0] rand_lane();
    int v;
    case ($urandom_range(0, 3))
      0: v = $urandom_range(0, 16) - 8;
      1: v = $urandom_range(0, 1) ? 32'h7FFF : -32768;
      default: v = int'($urandom);
    endcase
    return v[W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  logic [DW-1:0] d_relu, d_clip, d_leak, d_sat;

  initial begin
    d_relu = pack4(16'h0100, 16'hFF00, 16'h0000, 16'h7FFF);
    d_clip = pack4(16'h0700, 16'h0500, 16'h8000, 16'h0600);
    d_leak = pack4(16'hFFF8, 16'hFFFF, 16'h0010, 16'h8000);
    d_sat  = pack4(16'h0700, 16'h0700, 16'h0700, 16'h0700);

    rst = 1'b1; in_valid = 1'b1; mode = 2'd1; clip_max = '0; in_data = d_relu;
    out_ready = 1'b1; clr_cnt = 1'b0;

    // reset holds everything quiet even with in_valid high
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_clamp_cnt", 128'(clamp_cnt), 128'(0));
      check("rst_out_data", 128'({out_clamped, out_data}), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // first beat: out_valid appears two cycles after it is offered
    send_beat(2'd1, 16'h0000, d_relu, {4'b0000, pack4(16'h0100, 16'h0000, 16'h0000, 16'h7FFF)});
    check("latency_early", 128'(out_valid), 128'(0));
    tick();
    check("latency_valid", 128'(out_valid), 128'(1));

    send_beat(2'd0, 16'h0000, d_relu, {4'b0000, d_relu});
    send_beat(2'd2, 16'h0600, d_clip, {4'b0001, pack4(16'h0600, 16'h0500, 16'h0000, 16'h0600)});
    send_beat(2'd2, 16'hFF00, d_clip, {4'b1011, 64'h0});
    send_beat(2'd3, 16'h0000, d_leak, {4'b0000, pack4(16'hFFFF, 16'hFFFF, 16'h0010, 16'hF000)});
    drain();

    // counter saturation: 20 clamped lanes into a 4-bit counter
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    repeat (5) send_beat(2'd2, 16'h0600, d_sat, {4'b1111, pack4(16'h0600, 16'h0600, 16'h0600, 16'h0600)});
    drain();
    tick();
    check("cnt_saturate", 128'(clamp_cnt), 128'(15));

    // clear coincident with a clamped transfer
    out_ready = 1'b0;
    send_beat(2'd2, 16'h0600, d_sat, {4'b1111, pack4(16'h0600, 16'h0600, 16'h0600, 16'h0600)});
    tick();
    check("clr_pending_valid", 128'(out_valid), 128'(1));
    clr_cnt = 1'b1; out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_clr_wins", 128'(clamp_cnt), 128'(0));
    drain();

    // full stall: two beats fill the pipe, third is refused
    out_ready = 1'b0;
    send_model(2'd1, 16'h0000, d_leak);
    send_model(2'd3, 16'h0000, d_relu);
    mode = 2'd2; clip_max = 16'h0400; in_data = d_clip; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_model(2'd2, 16'h0400, d_clip);
    drain();

    // reset mid-operation discards in-flight beats
    out_ready = 1'b0;
    send_model(2'd0, 16'h0000, d_clip);
    send_model(2'd1, 16'h0000, d_leak);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;

    // randomized stream with random backpressure and per-beat mode changes
    rand_ready = 1;
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] d;
      logic [W-1:0]  c;
      for (int i = 0; i < L; i++) d[i*W +: W] = rand_lane();
      c = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800));
      clr_cnt = ($urandom_range(0, 9) == 0);
      send_model(2'($urandom_range(0, 3)), c, d);
      clr_cnt = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 0;
    tick();
    out_ready = 1'b1;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
